// File: rtl/num_pkg.sv
// Shared types and ASCII helpers for the shared decimal-converter arbiter.
package num_pkg;

  typedef enum logic [2:0] {
    FLUSH_SP    = 3'd0,
    FLUSH_DRAIN = 3'd1,
    ARB         = 3'd2,
    FWD         = 3'd3,
    RESULT      = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_SP = 8'h20;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/num_parse_arb_rr_arb.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arb
  import num_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned ID_W = 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [N-1:0]    rot;
  logic [ID_W-1:0] off;
  logic [ID_W:0]   sum;

  // Rotate so bit 0 is the request at ptr, then take the lowest set bit.
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = ID_W'(k);
        any = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= (ID_W + 1)'(N)) ? ID_W'(sum - (ID_W + 1)'(N)) : ID_W'(sum);
  end

endmodule

// File: rtl/num_parse_arb.sv
// Shares one decimal converter among N_SRC byte streams, one whole number per grant.
// Optional macro NUM_TIMEOUT_EN: inject a terminator after TIMEOUT idle cycles mid-number.
module num_parse_arb
  import num_pkg::*;
#(
  parameter int unsigned N_SRC   = 2,
  parameter int unsigned ID_W    = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*N_SRC-1:0]   s_dtm,
  input  logic [N_SRC-1:0]     s_vld,
  output logic [N_SRC-1:0]     s_rdy,
  output logic [7:0]           c_dtm,
  output logic                 c_vld,
  input  logic                 c_rdy,
  input  logic [31:0]          r_dtm,
  input  logic                 r_vld,
  output logic                 r_rdy,
  output logic [31:0]          n_dtm,
  output logic [ID_W-1:0]      n_id,
  output logic                 n_vld,
  input  logic                 n_rdy
);

  if (N_SRC < 2 || N_SRC > 8) begin : g_bad_nsrc
    $error("num_parse_arb: N_SRC must be 2..8");
  end
  if (ID_W != $clog2(N_SRC)) begin : g_bad_idw
    $error("num_parse_arb: ID_W must equal clog2(N_SRC)");
  end
  if (TIMEOUT < 1) begin : g_bad_to
    $error("num_parse_arb: TIMEOUT must be at least 1");
  end

  state_t          state, state_n;
  logic [ID_W-1:0] grant, grant_n;
  logic [ID_W-1:0] rr_ptr, rr_ptr_n;
  logic            seen_digit, seen_n;
  logic [ID_W-1:0] arb_idx;
  logic            arb_any;
  logic [ID_W-1:0] grant_inc;
  logic [7:0]      src_byte [N_SRC];
  logic [7:0]      cur_byte;
  logic            cur_vld;

`ifdef NUM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic            to_expired;
  assign to_expired = (to_cnt == TO_W'(TIMEOUT));
`endif

  for (genvar i = 0; i < int'(N_SRC); i++) begin : g_byte
    assign src_byte[i] = s_dtm[8*i +: 8];
  end

  assign cur_byte  = src_byte[grant];
  assign cur_vld   = s_vld[grant];
  assign grant_inc = (grant == ID_W'(N_SRC - 1)) ? '0 : grant + ID_W'(1);
  assign n_dtm     = r_dtm;

  rr_arb #(.N(N_SRC), .ID_W(ID_W)) u_rr_arb (
    .req (s_vld),
    .ptr (rr_ptr),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FLUSH_SP;
      grant      <= '0;
      rr_ptr     <= '0;
      seen_digit <= 1'b0;
`ifdef NUM_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      rr_ptr     <= rr_ptr_n;
      seen_digit <= seen_n;
`ifdef NUM_TIMEOUT_EN
      to_cnt     <= to_cnt_n;
`endif
    end
  end

  // Outputs are held at their idle values while rst is high.
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    rr_ptr_n = rr_ptr;
    seen_n   = seen_digit;
`ifdef NUM_TIMEOUT_EN
    to_cnt_n = to_cnt;
`endif
    s_rdy    = '0;
    c_dtm    = '0;
    c_vld    = 1'b0;
    r_rdy    = 1'b0;
    n_vld    = 1'b0;
    n_id     = '0;
    if (!rst) begin
      case (state)
        // Terminate whatever the un-reset converter holds; drop its result.
        FLUSH_SP: begin
          c_dtm = ASCII_SP;
          c_vld = 1'b1;
          r_rdy = 1'b1;
          if (c_rdy) state_n = FLUSH_DRAIN;
        end
        FLUSH_DRAIN: begin
          r_rdy   = 1'b1;
          state_n = ARB;
        end
        ARB: begin
          if (arb_any) begin
            grant_n = arb_idx;
            state_n = FWD;
          end
        end
        FWD: begin
`ifdef NUM_TIMEOUT_EN
          if (to_expired) begin
            c_dtm = ASCII_SP;
            c_vld = 1'b1;
            if (c_rdy) begin
              seen_n   = 1'b0;
              to_cnt_n = '0;
              state_n  = RESULT;
            end
          end else begin
`else
          begin
`endif
            c_dtm        = cur_byte;
            c_vld        = cur_vld;
            s_rdy[grant] = c_rdy;
            if (cur_vld && c_rdy) begin
`ifdef NUM_TIMEOUT_EN
              to_cnt_n = '0;
`endif
              if (is_digit(cur_byte)) begin
                seen_n = 1'b1;
              end else if (seen_digit) begin
                seen_n  = 1'b0;
                state_n = RESULT;
              end
            end else if (!cur_vld) begin
              // A source that has not started a number may not hold the converter.
              if (!seen_digit) begin
                rr_ptr_n = grant_inc;
                state_n  = ARB;
              end
`ifdef NUM_TIMEOUT_EN
              else begin
                to_cnt_n = to_cnt + TO_W'(1);
              end
`endif
            end
          end
        end
        RESULT: begin
          n_vld = r_vld;
          n_id  = grant;
          r_rdy = n_rdy;
          if (r_vld && n_rdy) begin
            rr_ptr_n = grant_inc;
            state_n  = ARB;
          end
        end
        default: state_n = FLUSH_SP;
      endcase
    end
  end

endmodule

// File: tb/tb_num_parse_arb.sv
// Scoreboard bench for num_parse_arb with a behavioural (reset-less) decimal converter.
module tb_num_parse_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_dtm;
  logic [1:0]  s_vld;
  logic [1:0]  s_rdy;
  logic [7:0]  c_dtm;
  logic        c_vld;
  logic        c_rdy;
  logic [31:0] r_dtm;
  logic        r_vld;
  logic        r_rdy;
  logic [31:0] n_dtm;
  logic [0:0]  n_id;
  logic        n_vld;
  logic        n_rdy;

  always #5 clk = ~clk;

  num_parse_arb #(.N_SRC(2), .ID_W(1), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_dtm (s_dtm),
    .s_vld (s_vld),
    .s_rdy (s_rdy),
    .c_dtm (c_dtm),
    .c_vld (c_vld),
    .c_rdy (c_rdy),
    .r_dtm (r_dtm),
    .r_vld (r_vld),
    .r_rdy (r_rdy),
    .n_dtm (n_dtm),
    .n_id  (n_id),
    .n_vld (n_vld),
    .n_rdy (n_rdy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [32:0] exp_q[$];
  logic [7:0]  log_q[$];
  logic [7:0]  exp_bytes[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_str(input int src, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (src == 0) q0.push_back(s[i]);
      else q1.push_back(s[i]);
    end
  endtask

  task automatic expect_bytes(input string s);
    for (int i = 0; i < s.len(); i++) exp_bytes.push_back(s[i]);
  endtask

  task automatic expect_result(input logic id, input logic [31:0] v);
    exp_q.push_back({id, v});
  endtask

  task automatic wait_done(input string name, input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && t < budget) begin
      tick(1);
      t++;
    end
    check({name, "_drain"}, 32'(exp_q.size() + q0.size() + q1.size()), 32'd0);
    tick(3);
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, 32'(log_q.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size() && i < log_q.size(); i++)
      check({name, "_byte"}, 32'(log_q[i]), 32'(exp_bytes[i]));
    log_q.delete();
    exp_bytes.delete();
  endtask

  // Source drivers: present queue fronts, pop on a completed handshake.
  initial begin
    logic [1:0] hs;
    logic [7:0] dump;
    s_vld = '0;
    s_dtm = '0;
    forever begin
      @(negedge clk);
      hs = s_vld & s_rdy;
      @(posedge clk);
      #1;
      if (hs[0]) dump = q0.pop_front();
      if (hs[1]) dump = q1.pop_front();
      s_vld[0]    = (q0.size() > 0);
      s_vld[1]    = (q1.size() > 0);
      s_dtm[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
      s_dtm[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
    end
  end

  // Converter model: no reset, one byte per cycle, stalls while a result is pending.
  initial begin
    logic        bhs, rhs, have;
    logic [7:0]  b;
    logic [31:0] acc;
    have  = 1'b0;
    acc   = '0;
    c_rdy = 1'b1;
    r_vld = 1'b0;
    r_dtm = '0;
    forever begin
      @(negedge clk);
      bhs = c_vld && c_rdy;
      b   = c_dtm;
      rhs = r_vld && r_rdy;
      @(posedge clk);
      #1;
      if (rhs) r_vld = 1'b0;
      if (bhs) begin
        log_q.push_back(b);
        if (b >= 8'h30 && b <= 8'h39) begin
          acc  = acc * 10 + 32'(b - 8'h30);
          have = 1'b1;
        end else if (have) begin
          r_dtm = acc;
          r_vld = 1'b1;
          acc   = '0;
          have  = 1'b0;
        end
      end
      c_rdy = !r_vld;
    end
  end

  // Monitor: every presented result must be expected; compare on handshake.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (n_vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected_n_vld", 32'(n_vld), 32'd0);
        end else if (n_rdy) begin
          e = exp_q.pop_front();
          check("result_id", 32'(n_id), 32'(e[32]));
          check("result_value", n_dtm, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    n_rdy = 1'b1;
    rst   = 1'b1;
    tick(2);
    check("rst_s_rdy", 32'(s_rdy), 32'd0);
    check("rst_c_vld", 32'(c_vld), 32'd0);
    check("rst_r_rdy", 32'(r_rdy), 32'd0);
    check("rst_n_vld", 32'(n_vld), 32'd0);
    check("rst_n_id", 32'(n_id), 32'd0);
    rst = 1'b0;
    tick(10);
    expect_bytes(" ");
    check_log("initial_flush");

    // Leave "12" inside the converter, then reset mid-number.
    push_str(0, "12");
    tick(5);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(6);
    expect_bytes("12 ");
    check_log("reset_flush");
    check("flush_drained", 32'(r_vld), 32'd0);
    check("arb_idle_c_vld", 32'(c_vld), 32'd0);
    check("arb_idle_s_rdy", 32'(s_rdy), 32'd0);

    // Contention from rr_ptr=0, then again after wrap.
    expect_result(1'b0, 32'd7);
    expect_result(1'b1, 32'd9);
    push_str(0, "7 ");
    push_str(1, "9 ");
    wait_done("contention", 100);
    expect_bytes("7 9 ");
    check_log("contention_bytes");

    expect_result(1'b0, 32'd8);
    expect_result(1'b1, 32'd6);
    push_str(0, "8 ");
    push_str(1, "6 ");
    wait_done("wrap", 100);
    expect_bytes("8 6 ");
    check_log("wrap_bytes");

    // Single source.
    expect_result(1'b0, 32'd42);
    push_str(0, "42 ");
    wait_done("single", 100);
    expect_bytes("42 ");
    check_log("single_bytes");

    // Backpressure in RESULT (rr_ptr=1 now).
    n_rdy = 1'b0;
    expect_result(1'b1, 32'd31);
    expect_result(1'b0, 32'd2);
    push_str(1, "31 ");
    t = 0;
    while (!n_vld && t < 50) begin
      tick(1);
      t++;
    end
    check("bp_reach_result", 32'(n_vld), 32'd1);
    push_str(0, "2 ");
    repeat (5) begin
      tick(1);
      check("bp_n_vld", 32'(n_vld), 32'd1);
      check("bp_n_dtm", n_dtm, 32'd31);
      check("bp_s_rdy", 32'(s_rdy), 32'd0);
    end
    check("bp_no_grant", 32'(q0.size()), 32'd2);
    n_rdy = 1'b1;
    wait_done("backpressure", 100);
    expect_bytes("31 2 ");
    check_log("bp_bytes");

    // Move rr_ptr back to 0.
    expect_result(1'b1, 32'd1);
    push_str(1, "1 ");
    wait_done("ptr_reset", 100);
    expect_bytes("1 ");
    check_log("ptr_reset_bytes");

    // Leading junk then idle: grant must move to src1.
    expect_result(1'b1, 32'd5);
    push_str(0, "x");
    push_str(1, "5 ");
    wait_done("idle_junk", 100);
    expect_bytes("x5 ");
    check_log("idle_junk_bytes");

`ifdef NUM_TIMEOUT_EN
    // Stalled source mid-number gets a forced terminator.
    expect_result(1'b0, 32'd3);
    push_str(0, "3");
    wait_done("timeout", 100);
    expect_bytes("3 ");
    check_log("timeout_bytes");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
